// File: rtl/usb_rx_timer.sv
// usb_rx_timer: receive-side bit/byte timing for the USB full-speed receiver.
// It recovers the bit clock from D+ edges, strobes once per bit at mid-bit,
// drops stuffed bits, and counts received bits, bytes and packet overflow.
//
// Parameters:
//   CLKS_PER_BIT     system clocks per USB bit time (>= 4)
//   SAMPLE_PHASE     phase value at which a bit is sampled
//                    (1 .. CLKS_PER_BIT-2)
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   rcving           receive in progress (first SYNC edge .. EOP)
//   d_edge           one-cycle pulse on any transition of synced D+
//   bit_stuff        marks the bit sampled by shift_enable as stuffed
//   max_packet_size  payload byte limit, 0 = unlimited
//   shift_enable     one-cycle mid-bit sample strobe (combinational)
//   byte_received    one-cycle pulse after the 8th real bit of a byte
//   byte_count       bytes in the current/last packet, saturates at 127
//   packet_overflow  sticky: a byte arrived beyond max_packet_size
//   drift_err        sticky: edge seen too close to the sample point
// Optional feature:
//   RX_TIMER_DRIFT_CHECK_EN  builds the drift_err window check; when the
//                            macro is undefined drift_err is tied to 0.

module usb_rx_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       bit_stuff,
  input  logic [6:0] max_packet_size,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [6:0] byte_count,
  output logic       packet_overflow,
  output logic       drift_err
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  localparam logic [PW-1:0] SP   = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  localparam logic [6:0] CNT_MAX = 7'd127;

  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic          rcving_q;

  logic rise;
  logic take_bit;
  logic byte_done;
  logic size_limited;
  logic at_limit;

  // Start of a new packet: clears the sticky per-packet status.
  assign rise = rcving & ~rcving_q;

  // Strobe is gated by rcving so a fall on the sample cycle drops the bit.
  assign shift_enable = rcving && (phase == SP);

  assign take_bit  = shift_enable & ~bit_stuff;
  assign byte_done = take_bit && (bit_cnt == 3'd7);

  assign size_limited = (max_packet_size != 7'd0);
  assign at_limit     = (byte_count == max_packet_size);

  // Bit-clock recovery: an edge re-centres the phase so the next
  // sample lands SAMPLE_PHASE-1 clocks later, otherwise free-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (!rcving) begin
      phase <= '0;
    end else if (d_edge) begin
      phase <= ONE;
    end else if (phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + ONE;
    end
  end

  // Bit position within the byte; a partial byte is dropped
  // as soon as rcving goes low.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
    end else if (!rcving) begin
      bit_cnt <= 3'd0;
    end else if (take_bit) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcving_q <= 1'b0;
    end else begin
      rcving_q <= rcving;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_received <= 1'b0;
    end else begin
      byte_received <= byte_done;
    end
  end

  // Packet length survives the end of the packet so the control
  // FSM can read it after EOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count <= 7'd0;
    end else if (rise) begin
      byte_count <= 7'd0;
    end else if (byte_done && byte_count != CNT_MAX) begin
      byte_count <= byte_count + 7'd1;
    end
  end

  // Compared against the count before this byte is added, so the
  // flag rises with the first byte past the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      packet_overflow <= 1'b0;
    end else if (rise) begin
      packet_overflow <= 1'b0;
    end else if (byte_done && size_limited && at_limit) begin
      packet_overflow <= 1'b1;
    end
  end

`ifdef RX_TIMER_DRIFT_CHECK_EN
  localparam logic [PW-1:0] WIN_LO = PW'(SAMPLE_PHASE - 1);
  localparam logic [PW-1:0] WIN_SZ = PW'(2);

  logic [PW-1:0] win_dist;
  logic          in_window;

  // Window is SAMPLE_PHASE-1 .. SAMPLE_PHASE+1; the offset form keeps
  // the compare free of a constant lower bound that may be zero.
  assign win_dist  = phase - WIN_LO;
  assign in_window = (win_dist <= WIN_SZ);

  always_ff @(posedge clk) begin
    if (rst) begin
      drift_err <= 1'b0;
    end else if (rise) begin
      drift_err <= 1'b0;
    end else if (rcving && d_edge && in_window) begin
      drift_err <= 1'b1;
    end
  end
`else
  assign drift_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_timer.sv
// tb_usb_rx_timer: randomized plus directed scoreboard bench for usb_rx_timer.
// A phase-anchor reference model predicts strobes, bytes and sticky status.

module tb_usb_rx_timer;

  localparam int CPB = 8;
  localparam int SP  = 3;

`ifdef RX_TIMER_DRIFT_CHECK_EN
  localparam bit DRIFT_ON = 1'b1;
`else
  localparam bit DRIFT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rcving = 1'b0;
  logic       d_edge = 1'b0;
  logic       bit_stuff = 1'b0;
  logic [6:0] max_packet_size = 7'd0;
  logic       shift_enable;
  logic       byte_received;
  logic [6:0] byte_count;
  logic       packet_overflow;
  logic       drift_err;

  usb_rx_timer #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_PHASE(SP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rcving         (rcving),
    .d_edge         (d_edge),
    .bit_stuff      (bit_stuff),
    .max_packet_size(max_packet_size),
    .shift_enable   (shift_enable),
    .byte_received  (byte_received),
    .byte_count     (byte_count),
    .packet_overflow(packet_overflow),
    .drift_err      (drift_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int cnt;
    bit ovf;
    bit drf;
  } st_t;

  int  shq[$];
  int  brq[$];
  st_t stq[$];

  int checks = 0;
  int passed = 0;
  bit mon_on = 1'b0;

  // Reference model: the phase is the cycle distance from the last
  // anchor (rcving low or an edge), reduced modulo the bit time.
  int anchor = 0;
  bit m_prev = 1'b0;
  int m_bits = 0;
  int m_bytes = 0;
  bit m_ovf = 1'b0;
  bit m_drift = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d",
                  name, cyc, act, exp);
  endtask

  function automatic int mphase();
    return (cyc - anchor) % CPB;
  endfunction

  function automatic void model_step(input int n, input bit r, rc, e, s,
                                     input int mps);
    int  ph;
    bit  sh;
    bit  rise;
    st_t rec;
    ph = (n - anchor) % CPB;
    sh = rc && (ph == SP);
    if (sh) shq.push_back(n);
    if (r) begin
      anchor = n + 1;
      m_bits = 0;
      m_bytes = 0;
      m_ovf = 0;
      m_drift = 0;
      m_prev = 0;
    end else begin
      rise = rc && !m_prev;
      if (rise) begin
        m_bytes = 0;
        m_ovf = 0;
        m_drift = 0;
      end
      if (sh && !s) begin
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0;
          if (mps != 0 && m_bytes == mps) m_ovf = 1;
          if (m_bytes < 127) m_bytes++;
          brq.push_back(n + 1);
        end
      end
      if (DRIFT_ON && rc && e && !rise && ph >= SP - 1 && ph <= SP + 1)
        m_drift = 1;
      if (!rc) begin
        anchor = n + 1;
        m_bits = 0;
      end else if (e) begin
        anchor = n;
      end
      m_prev = rc;
    end
    rec.c = n + 1;
    rec.cnt = m_bytes;
    rec.ovf = m_ovf;
    rec.drf = m_drift;
    stq.push_back(rec);
  endfunction

  task automatic drive(input bit r, rc, e, s);
    rst = r;
    rcving = rc;
    d_edge = e;
    bit_stuff = s;
    model_step(cyc, r, rc, e, s, int'(max_packet_size));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, 0, 0);
  endtask

  task automatic run(input int k);
    repeat (k) drive(0, 1, 0, 0);
  endtask

  // Monitor: compares every presented output against the scoreboard.
  always @(negedge clk) begin
    int  n;
    bit  e;
    st_t s;
    if (mon_on) begin
      n = cyc;
      e = (shq.size() > 0) && (shq[0] == n);
      if (e) void'(shq.pop_front());
      chk("shift_enable", shift_enable, e);
      e = (brq.size() > 0) && (brq[0] == n);
      if (e) void'(brq.pop_front());
      chk("byte_received", byte_received, e);
      if (stq.size() > 0 && stq[0].c == n) begin
        s = stq.pop_front();
        chk("byte_count", byte_count, s.cnt);
        chk("packet_overflow", packet_overflow, s.ovf);
        chk("drift_err", drift_err, s.drf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sidx;
    bit st;
    bit rc;
    @(posedge clk);
    #1;
    anchor = cyc;
    mon_on = 1'b1;

    // Reset state
    repeat (3) drive(1, 0, 0, 0);
    chk("rst_shift", shift_enable, 0);
    chk("rst_byte_rx", byte_received, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_ovf", packet_overflow, 0);
    chk("rst_drift", drift_err, 0);

    // One free-running byte after a rise with an edge
    idle(5);
    drive(0, 1, 1, 0);
    run(64);
    chk("one_byte_count", byte_count, 1);
    idle(3);

    // Resync by a mid-bit edge
    drive(0, 1, 1, 0);
    run(16);
    drive(0, 1, 1, 0);
    run(40);
    idle(2);

    // Stuffed 4th strobe delays the byte by one bit
    sidx = 0;
    drive(0, 1, 1, 0);
    repeat (9 * CPB + 2) begin
      st = (mphase() == SP) && (sidx == 3);
      if (mphase() == SP) sidx++;
      drive(0, 1, 0, st);
    end
    chk("stuff_count", byte_count, 1);
    idle(2);

    // Overflow with a limit of 2 bytes
    max_packet_size = 7'd2;
    drive(0, 1, 1, 0);
    run(3 * 8 * CPB + 4);
    chk("ovf_set", packet_overflow, 1);
    chk("ovf_count", byte_count, 3);
    idle(4);
    chk("ovf_hold", packet_overflow, 1);
    chk("count_hold", byte_count, 3);

    // Partial byte; the new rise clears count and overflow
    max_packet_size = 7'd0;
    drive(0, 1, 1, 0);
    run(5 * CPB);
    idle(3);
    chk("partial_count", byte_count, 0);
    chk("partial_ovf", packet_overflow, 0);

    // Unlimited packet: 4 bytes, no overflow
    drive(0, 1, 1, 0);
    run(4 * 8 * CPB + 4);
    chk("nolimit_count", byte_count, 4);
    chk("nolimit_ovf", packet_overflow, 0);
    idle(3);

    // Reset in the middle of a byte
    drive(0, 1, 1, 0);
    run(64 + 20);
    drive(1, 1, 0, 0);
    chk("midrst_shift", shift_enable, 0);
    chk("midrst_byte_rx", byte_received, 0);
    chk("midrst_count", byte_count, 0);
    chk("midrst_ovf", packet_overflow, 0);
    chk("midrst_drift", drift_err, 0);
    idle(3);

    // Edge at the sample phase
    drive(0, 1, 1, 0);
    repeat (CPB) if (mphase() != SP) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    chk("drift_set", drift_err, DRIFT_ON);
    run(10);
    idle(3);
    chk("drift_hold", drift_err, DRIFT_ON);
    drive(0, 1, 0, 0);
    chk("drift_clear", drift_err, 0);
    run(5);
    idle(3);

    // Randomized traffic
    rc = 1'b0;
    repeat (3000) begin
      if (rc) rc = ($urandom_range(0, 199) != 0);
      else begin
        rc = ($urandom_range(0, 9) == 0);
        if (rc) max_packet_size = 7'($urandom_range(0, 3));
      end
      drive(($urandom_range(0, 499) == 0), rc,
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 5) == 0));
    end
    idle(4);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_timer.md
# usb_rx_timer

Receive-side bit/byte timing for the USB full-speed receiver, the counterpart of the transmit timer. It recovers the bit clock from edges on the synchronized D+ line, issues one sample strobe per bit at mid-bit, discards stuffed bits, and counts received bits, bytes and packet overflow. It sits between the edge detector / NRZI decoder and the receive shift register and control FSM.

## Interface
- `CLKS_PER_BIT`, default 8: system clocks per USB bit time (96 MHz / 12 Mbps); must be ≥ 4.
- `SAMPLE_PHASE`, default 3: phase value at which the bit is sampled; must satisfy 1 ≤ SAMPLE_PHASE ≤ CLKS_PER_BIT-2.
- `clk  in  1`  system clock; all logic on the rising edge.
- `rst  in  1`  reset, synchronous and active-high.
- `rcving  in  1`  receive in progress; high from the first SYNC edge to EOP.
- `d_edge  in  1`  one-cycle pulse on any transition of synchronized D+.
- `bit_stuff  in  1`  qualifies the current `shift_enable`: high marks the sampled bit as stuffed, so it is discarded.
- `max_packet_size  in  7`  maximum payload bytes; 0 = no limit.
- `shift_enable  out  1`  one-cycle mid-bit sample strobe.
- `byte_received  out  1`  one-cycle pulse after the 8th non-stuffed bit of a byte.
- `byte_count  out  7`  bytes received in the current/last packet, saturating at 127.
- `packet_overflow  out  1`  sticky; a byte arrived beyond `max_packet_size`.
- `drift_err  out  1`  sticky edge-timing error (see Configuration).

## Operation
- Phase counter, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps to 0.
- `rcving` low: phase = 0 and bit counter = 0, both held. `byte_received` = 0.
- `rcving` high, `d_edge` high in cycle t: phase = 1 in cycle t+1. This resync overrides increment and wrap.
- `rcving` high, no edge: phase increments by one.
- `shift_enable` = `rcving` && (phase == SAMPLE_PHASE). This is combinational from the registered phase. An edge in the strobe cycle does not suppress that strobe.
- Bit counter (3 bits, 0..7) increments on `shift_enable` && !`bit_stuff`. A stuffed sample leaves it unchanged.
- When the bit counter wraps 7→0:
  - `byte_received` is registered high for exactly the next cycle.
  - `byte_count` increments in that same cycle and saturates at 127.
- Overflow: `packet_overflow` sets on a byte completion when `max_packet_size` ≠ 0 and `byte_count` == `max_packet_size` before the increment.
- Rising edge of `rcving` (detected via a registered copy): `byte_count`, `packet_overflow` and `drift_err` clear to 0. Otherwise they hold their value after `rcving` falls, so the FSM can read the packet length.
- Partial byte at `rcving` fall: its bits are discarded with no `byte_received` pulse.

## Timing
- Reset values: phase 0, bit counter 0, `shift_enable` 0, `byte_received` 0, `byte_count` 0, `packet_overflow` 0, `drift_err` 0.
- Latency from edge to sample: `d_edge` at cycle t gives `shift_enable` at t+SAMPLE_PHASE (t+3 by default).
- Without edges, strobes repeat every CLKS_PER_BIT cycles.
- Latency from strobe to byte: `byte_received` and the new `byte_count` appear 1 cycle after the completing `shift_enable`.
- Simultaneous `rcving` rise and `d_edge`: the counters clear and phase = 1 in the next cycle.
- `rst` mid-packet: all state returns to reset values in the next cycle, regardless of other inputs.
- `rcving` fall in the same cycle as a completing strobe: `shift_enable` is 0 in that cycle, because it is gated by `rcving`, so no byte is counted.

## Configuration
- `RX_TIMER_DRIFT_CHECK_EN` defined: `drift_err` sets when `d_edge` arrives while `rcving` is high and phase is within SAMPLE_PHASE-1..SAMPLE_PHASE+1. This means the edge is too close to the sample point. It is cleared only by `rst` or a `rcving` rise.
- Macro undefined: `drift_err` is tied to 0 and no window comparison logic is built.

## Test plan
- Defaults, `rcving` rises with `d_edge` at cycle 10 and no further edges: `shift_enable` at cycles 13, 21, 29, …; `byte_received` at cycle 70; `byte_count` = 1.
- Edge re-sync: after the strobe at cycle 21, inject `d_edge` at cycle 26 → next strobe at 29 (not 29 by free-run coincidence): check with edge at 27 → strobe at 30.
- `bit_stuff` high on the 4th strobe of a byte: `byte_received` is delayed by exactly 8 cycles, and `byte_count` counts only 8 real bits.
- `max_packet_size` = 2, send 3 bytes: `packet_overflow` rises with the 3rd `byte_received` and `byte_count` = 3. Send 4 bytes with `max_packet_size` = 0: no overflow.
- Drop `rcving` after 5 bits: no `byte_received`; `byte_count` holds. The next `rcving` rise clears `byte_count` and `packet_overflow`. Assert `rst` mid-byte: all outputs are 0 in the next cycle.
- With `RX_TIMER_DRIFT_CHECK_EN`: `d_edge` at phase 3 → `drift_err` = 1 in the next cycle and stays until a `rcving` rise. Without the macro, the same stimulus leaves `drift_err` = 0.
